// File: rtl/led_status_pkg.sv
// Shared defaults and counter-width helper for the front-panel LED status generator.
package led_status_pkg;

  localparam int unsigned DefNports       = 8;
  localparam int unsigned DefTickDiv      = 50000;
  localparam int unsigned DefBlinkTicks   = 100;
  localparam int unsigned DefStretchTicks = 50;
  localparam int unsigned DefDebTicks     = 20;

  // Bits needed to hold max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/led_status_if.sv
// Port bundle between the port-status sources and the LED status generator.
interface led_status_if #(
  parameter int unsigned NPORTS = led_status_pkg::DefNports
);
  logic [NPORTS-1:0] link_raw_n;
  logic [NPORTS-1:0] act_pulse;
  logic              lamp_test;
  logic              blink;
  logic [NPORTS-1:0] link;
  logic [NPORTS-1:0] act;

  modport master (
    output link_raw_n, act_pulse, lamp_test,
    input  blink, link, act
  );

  modport slave (
    input  link_raw_n, act_pulse, lamp_test,
    output blink, link, act
  );
endinterface

// File: rtl/led_status_gen_port_ctl.sv
// One port's link synchroniser, tick-based debouncer and activity stretcher.
module led_port_ctl
  import led_status_pkg::*;
#(
  parameter int unsigned STRETCH_TICKS = DefStretchTicks,
  parameter int unsigned DEB_TICKS     = DefDebTicks
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic link_raw_n_i,
  input  logic act_pulse_i,
  output logic link_o,
  output logic act_o
);

  localparam int unsigned DebW = cnt_width(DEB_TICKS - 1);
  localparam int unsigned StrW = cnt_width(STRETCH_TICKS);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_TICKS - 1);
  localparam logic [StrW-1:0] StrLoad = StrW'(STRETCH_TICKS);
  localparam logic [StrW-1:0] StrOne  = StrW'(1);

  logic [1:0]      sync_q, sync_d;
  logic [DebW-1:0] deb_q, deb_d;
  logic [StrW-1:0] str_q, str_d;
  logic            link_q, link_d;
  logic            act_q, act_d;
  logic            link_s;

  always_comb begin
    sync_d = {sync_q[0], link_raw_n_i};
    link_s = sync_q[1];

    link_d = link_q;
    deb_d  = deb_q;
    if (link_s == link_q) begin
      deb_d = '0;
    end else if (tick_i) begin
      if (deb_q == DebLast) begin
        link_d = link_s;
        deb_d  = '0;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end

    // Uses link_d so a dropping link kills activity on the same edge.
    act_d = act_q;
    str_d = str_q;
    if (link_d) begin
      act_d = 1'b1;
      str_d = '0;
    end else if (act_pulse_i) begin
      act_d = 1'b0;
      str_d = StrLoad;
    end else if (tick_i && (str_q > StrOne)) begin
      str_d = str_q - 1'b1;
    end else if (tick_i && (str_q == StrOne)) begin
      str_d = '0;
      act_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      deb_q  <= '0;
      str_q  <= '0;
      link_q <= 1'b1;
      act_q  <= 1'b1;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      str_q  <= str_d;
      link_q <= link_d;
      act_q  <= act_d;
    end
  end

  assign link_o = link_q;
  assign act_o  = act_q;

endmodule

// File: rtl/led_status_gen.sv
// Front-panel LED status: shared timebase and blink, per-port link/activity, lamp test.
module led_status_gen
  import led_status_pkg::*;
#(
  parameter int unsigned NPORTS        = DefNports,
  parameter int unsigned TICK_DIV      = DefTickDiv,
  parameter int unsigned BLINK_TICKS   = DefBlinkTicks,
  parameter int unsigned STRETCH_TICKS = DefStretchTicks,
  parameter int unsigned DEB_TICKS     = DefDebTicks
) (
  input logic         clk,
  input logic         rst,
  led_status_if.slave bus
);

  localparam int unsigned PresW = cnt_width(TICK_DIV - 1);
  localparam int unsigned BlnkW = cnt_width(BLINK_TICKS - 1);
  localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);
  localparam logic [BlnkW-1:0] BlnkLast = BlnkW'(BLINK_TICKS - 1);

  logic [PresW-1:0]  pres_q, pres_d;
  logic [BlnkW-1:0]  bcnt_q, bcnt_d;
  logic              blink_q, blink_d;
  logic              tick;
  logic [NPORTS-1:0] link_int;
  logic [NPORTS-1:0] act_int;

  always_comb begin
    tick    = (pres_q == PresLast);
    pres_d  = tick ? '0 : pres_q + 1'b1;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (tick) begin
      if (bcnt_q == BlnkLast) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pres_q  <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      pres_q  <= pres_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    led_port_ctl #(
      .STRETCH_TICKS (STRETCH_TICKS),
      .DEB_TICKS     (DEB_TICKS)
    ) u_port (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (tick),
      .link_raw_n_i (bus.link_raw_n[i]),
      .act_pulse_i  (bus.act_pulse[i]),
      .link_o       (link_int[i]),
      .act_o        (act_int[i])
    );
  end

  // Lamp test overrides only the outputs; the registers keep running underneath.
  assign bus.blink = blink_q;
  assign bus.link  = bus.lamp_test ? '0 : link_int;
  assign bus.act   = bus.lamp_test ? '0 : act_int;

endmodule

// File: tb/tb_led_status_gen.sv
// Directed bench for led_status_gen with a shortened timebase.
module tb_led_status_gen;

  logic clk = 1'b0;
  logic rst;
  int   cyc;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  led_status_if #(.NPORTS(8)) bus ();

  led_status_gen #(
    .NPORTS        (8),
    .TICK_DIV      (4),
    .BLINK_TICKS   (2),
    .STRETCH_TICKS (3),
    .DEB_TICKS     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Cycle n is the interval ending at edge n; edge 0 is the first edge out of reset.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.link_raw_n = '1;
    bus.act_pulse  = '0;
    bus.lamp_test  = 1'b0;

    // Free-running timebase and blink, no port stimulus
    do_reset();
    for (int n = 0; n <= 17; n++) begin
      goto(n);
      check_eq($sformatf("tick c%0d", n), 32'(dut.tick), 32'((n % 4) == 3));
      check_eq($sformatf("blink c%0d", n), 32'(bus.blink), 32'((n >= 8) && (n < 16)));
      check_eq($sformatf("idle link c%0d", n), 32'(bus.link), 32'hFF);
      check_eq($sformatf("idle act c%0d", n), 32'(bus.act), 32'hFF);
    end

    // Link debounce then a single activity pulse
    do_reset();
    bus.link_raw_n = 8'hFE;
    goto(7);  check_eq("deb link c7", 32'(bus.link), 32'hFF);
    goto(8);  check_eq("deb link c8", 32'(bus.link), 32'hFE);
              check_eq("up act c8", 32'(bus.act), 32'hFF);
    goto(20); bus.act_pulse = 8'h01;
              check_eq("act c20", 32'(bus.act), 32'hFF);
    goto(21); bus.act_pulse = 8'h00;
              check_eq("act c21", 32'(bus.act), 32'hFE);
    goto(24); check_eq("str c24", 32'(dut.g_port[0].u_port.str_q), 32'd2);
    goto(28); check_eq("str c28", 32'(dut.g_port[0].u_port.str_q), 32'd1);
    goto(31); check_eq("act c31", 32'(bus.act), 32'hFE);
    goto(32); check_eq("act c32", 32'(bus.act), 32'hFF);
              check_eq("str c32", 32'(dut.g_port[0].u_port.str_q), 32'd0);

    // Retrigger, then a pulse coinciding with the expiring tick
    do_reset();
    bus.link_raw_n = 8'hFE;
    goto(20); bus.act_pulse = 8'h01;
    goto(21); bus.act_pulse = 8'h00;
    goto(30); bus.act_pulse = 8'h01;
    goto(31); bus.act_pulse = 8'h00;
    goto(32); check_eq("retrig act c32", 32'(bus.act), 32'hFE);
    goto(39); check_eq("retrig act c39", 32'(bus.act), 32'hFE);
    goto(40); check_eq("retrig act c40", 32'(bus.act), 32'hFF);
    goto(41); bus.act_pulse = 8'h01;
    goto(42); bus.act_pulse = 8'h00;
    goto(48); check_eq("str c48", 32'(dut.g_port[0].u_port.str_q), 32'd1);
    goto(51); bus.act_pulse = 8'h01;
    goto(52); bus.act_pulse = 8'h00;
              check_eq("tie act c52", 32'(bus.act), 32'hFE);
              check_eq("tie str c52", 32'(dut.g_port[0].u_port.str_q), 32'd3);

    // Link drop while active: act releases on the same edge link goes down
    do_reset();
    bus.link_raw_n = 8'hFE;
    goto(22); bus.link_raw_n = 8'hFF;
    goto(28); bus.act_pulse = 8'h01;
    goto(29); bus.act_pulse = 8'h00;
              check_eq("drop act c29", 32'(bus.act), 32'hFE);
    goto(31); check_eq("drop link c31", 32'(bus.link), 32'hFE);
              check_eq("drop act c31", 32'(bus.act), 32'hFE);
    goto(32); check_eq("drop link c32", 32'(bus.link), 32'hFF);
              check_eq("drop act c32", 32'(bus.act), 32'hFF);
    goto(34); bus.act_pulse = 8'h01;
    goto(35); bus.act_pulse = 8'h00;
              check_eq("down act c35", 32'(bus.act), 32'hFF);
    goto(36); check_eq("down act c36", 32'(bus.act), 32'hFF);

    // Three-cycle glitch on port 1 never reaches the debounce limit
    do_reset();
    for (int n = 0; n <= 24; n++) begin
      goto(n);
      if (n == 5) bus.link_raw_n = 8'hFD;
      if (n == 8) bus.link_raw_n = 8'hFF;
      check_eq($sformatf("glitch link c%0d", n), 32'(bus.link), 32'hFF);
      if (n == 8)  check_eq("glitch deb c8", 32'(dut.g_port[1].u_port.deb_q), 32'd1);
      if (n == 11) check_eq("glitch deb c11", 32'(dut.g_port[1].u_port.deb_q), 32'd0);
    end

    // Lamp test overlay, then reset mid-stretch
    do_reset();
    bus.link_raw_n = 8'hFE;
    goto(10); bus.act_pulse = 8'h01;
    goto(11); bus.act_pulse = 8'h00;
              check_eq("pre-lamp act c11", 32'(bus.act), 32'hFE);
    goto(12); bus.lamp_test = 1'b1;
              #1;
              check_eq("lamp link", 32'(bus.link), 32'h00);
              check_eq("lamp act", 32'(bus.act), 32'h00);
              check_eq("lamp blink", 32'(bus.blink), 32'd1);
    goto(13); bus.lamp_test = 1'b0;
              #1;
              check_eq("post-lamp link", 32'(bus.link), 32'hFE);
              check_eq("post-lamp act", 32'(bus.act), 32'hFE);
    goto(14); rst = 1'b1;
    goto(15); rst = 1'b0;
              check_eq("rst blink", 32'(bus.blink), 32'd0);
              check_eq("rst link", 32'(bus.link), 32'hFF);
              check_eq("rst act", 32'(bus.act), 32'hFF);
              check_eq("rst str", 32'(dut.g_port[0].u_port.str_q), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
